// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    localparam int unsigned PC_INCR   = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its surroundings (PC register, imem, branch unit, ID).
interface fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] PCResult;
    logic [ADDR_W-1:0] PCNext;
    logic              ImemReq;
    logic [ADDR_W-1:0] ImemAddr;
    logic              ImemAck;
    logic [DATA_W-1:0] ImemData;
    logic              BranchTaken;
    logic [ADDR_W-1:0] BranchTarget;
    logic              Stall;
    logic              IFID_Valid;
    logic [DATA_W-1:0] IFID_Instr;
    logic [ADDR_W-1:0] IFID_PCPlus4;

    modport master (
        input  PCResult, ImemAck, ImemData, BranchTaken, BranchTarget, Stall,
        output PCNext, ImemReq, ImemAddr, IFID_Valid, IFID_Instr, IFID_PCPlus4
    );

    modport slave (
        output PCResult, ImemAck, ImemData, BranchTaken, BranchTarget, Stall,
        input  PCNext, ImemReq, ImemAddr, IFID_Valid, IFID_Instr, IFID_PCPlus4
    );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holder for an instruction and its PC+4 that arrived while IF/ID was stalled.
module fetch_skid_buffer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              unload_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [ADDR_W-1:0] pcplus4_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] pcplus4_o
);
    import fetch_pkg::*;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;

    // Clear (flush) dominates a simultaneous load.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d   = 1'b1;
            instr_d   = instr_i;
            pcplus4_d = pcplus4_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            instr_q   <= DATA_W'(NOP_INSTR);
            pcplus4_q <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
        end
    end

    assign valid_o   = valid_q;
    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives imem from the PC, computes PCNext and fills the IF/ID register,
// with stall back-pressure absorbed by a one-entry skid buffer and branch redirect flushing.
module fetch_stage #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           Clk,
    input logic           Reset,
    fetch_stage_if.master bus
);
    import fetch_pkg::*;

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0] ifid_pc4_q, ifid_pc4_d;

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] pc_aligned;
    logic [ADDR_W-1:0] target_aligned;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              ifid_free;

    logic              skid_load, skid_unload, skid_clear;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_instr;
    logic [ADDR_W-1:0] skid_pc4;

    assign pc_plus4       = bus.PCResult + ADDR_W'(PC_INCR);
    assign pc_aligned     = bus.PCResult & WORD_MASK;
    assign target_aligned = bus.BranchTarget & WORD_MASK;
    assign ifid_free      = !ifid_valid_q || !bus.Stall;

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        pc_next      = bus.PCResult;
        imem_req     = 1'b0;
        imem_addr    = '0;
        ifid_valid_d = ifid_valid_q && bus.Stall;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req   = 1'b1;
                imem_addr  = pc_aligned;
                req_addr_d = pc_aligned;
                if (bus.ImemAck && !bus.BranchTaken) begin
                    pc_next = pc_plus4;
                    if (ifid_free) begin
                        ifid_valid_d = 1'b1;
                        ifid_instr_d = bus.ImemData;
                        ifid_pc4_d   = pc_plus4;
                    end else begin
                        skid_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else if (!bus.ImemAck && bus.BranchTaken) begin
                    state_d = DISCARD;
                end
            end
            HOLD: begin
                if (!bus.Stall) begin
                    ifid_valid_d = 1'b1;
                    ifid_instr_d = skid_instr;
                    ifid_pc4_d   = skid_pc4;
                    skid_unload  = 1'b1;
                    state_d      = FETCH;
                end
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = req_addr_q;
                // An ack here retires the stale request even if a new redirect arrives with it.
                if (bus.ImemAck) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.BranchTaken) begin
            pc_next      = target_aligned;
            ifid_valid_d = 1'b0;
            ifid_instr_d = ifid_instr_q;
            ifid_pc4_d   = ifid_pc4_q;
            skid_clear   = 1'b1;
            skid_load    = 1'b0;
            skid_unload  = 1'b0;
            if (state_q == HOLD || state_q == IDLE) begin
                state_d = FETCH;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= DATA_W'(NOP_INSTR);
            ifid_pc4_q   <= RESET_PC;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    fetch_skid_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (Clk),
        .rst_n     (Reset),
        .load_i    (skid_load),
        .unload_i  (skid_unload),
        .clear_i   (skid_clear),
        .instr_i   (bus.ImemData),
        .pcplus4_i (pc_plus4),
        .valid_o   (skid_valid),
        .instr_o   (skid_instr),
        .pcplus4_o (skid_pc4)
    );

    // Occupancy is implied by the HOLD state; the flag is kept for observability only.
    logic skid_valid_unused;
    assign skid_valid_unused = skid_valid;

    assign bus.PCNext       = pc_next;
    assign bus.ImemReq      = imem_req;
    assign bus.ImemAddr     = imem_addr;
    assign bus.IFID_Valid   = ifid_valid_q;
    assign bus.IFID_Instr   = ifid_instr_q;
    assign bus.IFID_PCPlus4 = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with a behavioural PC register closing the loop.
module tb_fetch_stage;

    logic clk;
    logic rst_n;

    fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) ifc ();

    fetch_stage #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register: loads PCNext every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ifc.PCResult <= 32'h0;
        else        ifc.PCResult <= ifc.PCNext;
    end

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        br;
        logic [31:0] tgt;
        logic        stall;
        logic [31:0] e_pcnext;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
    } vec_t;

    vec_t vq[$];
    int   total;
    int   bad;

    task automatic add(input logic ack, input logic [31:0] data, input logic br,
                       input logic [31:0] tgt, input logic stall,
                       input logic [31:0] pcn, input logic req, input logic [31:0] addr,
                       input logic v, input logic [31:0] instr, input logic [31:0] pc4);
        vec_t r;
        r.ack = ack; r.data = data; r.br = br; r.tgt = tgt; r.stall = stall;
        r.e_pcnext = pcn; r.e_req = req; r.e_addr = addr;
        r.e_v = v; r.e_instr = instr; r.e_pc4 = pc4;
        vq.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic [31:0] data, input logic br,
                         input logic [31:0] tgt, input logic stall);
        ifc.ImemAck      = ack;
        ifc.ImemData     = data;
        ifc.BranchTaken  = br;
        ifc.BranchTarget = tgt;
        ifc.Stall        = stall;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        //   ack data         br tgt          st  pcnext       req addr         v  instr        pc4
        add(0, 32'h0,        0, 32'h0,       0, 32'h0,       0, 32'h0,       0, 32'h0,       32'h0);
        add(1, 32'h11111111, 0, 32'h0,       0, 32'h4,       1, 32'h0,       1, 32'h11111111, 32'h4);
        add(1, 32'h22222222, 0, 32'h0,       0, 32'h8,       1, 32'h4,       1, 32'h22222222, 32'h8);
        add(1, 32'h33333333, 0, 32'h0,       0, 32'hC,       1, 32'h8,       1, 32'h33333333, 32'hC);
        add(1, 32'h44444444, 0, 32'h0,       0, 32'h10,      1, 32'hC,       1, 32'h44444444, 32'h10);
        add(0, 32'h0,        0, 32'h0,       0, 32'h10,      1, 32'h10,      0, 32'h44444444, 32'h10);
        add(0, 32'h0,        0, 32'h0,       0, 32'h10,      1, 32'h10,      0, 32'h44444444, 32'h10);
        add(1, 32'h55555555, 0, 32'h0,       0, 32'h14,      1, 32'h10,      1, 32'h55555555, 32'h14);
        add(0, 32'h0,        0, 32'h0,       1, 32'h14,      1, 32'h14,      1, 32'h55555555, 32'h14);
        add(1, 32'hAABBCCDD, 0, 32'h0,       1, 32'h18,      1, 32'h14,      1, 32'h55555555, 32'h14);
        add(0, 32'h0,        0, 32'h0,       1, 32'h18,      0, 32'h0,       1, 32'h55555555, 32'h14);
        add(0, 32'h0,        0, 32'h0,       0, 32'h18,      0, 32'h0,       1, 32'hAABBCCDD, 32'h18);
        add(1, 32'h66666666, 0, 32'h0,       0, 32'h1C,      1, 32'h18,      1, 32'h66666666, 32'h1C);
        add(1, 32'h77777777, 0, 32'h0,       0, 32'h20,      1, 32'h1C,      1, 32'h77777777, 32'h20);
        add(0, 32'h0,        0, 32'h0,       0, 32'h20,      1, 32'h20,      0, 32'h77777777, 32'h20);
        add(0, 32'h0,        1, 32'h100,     0, 32'h100,     1, 32'h20,      0, 32'h77777777, 32'h20);
        add(0, 32'h0,        0, 32'h0,       0, 32'h100,     1, 32'h20,      0, 32'h77777777, 32'h20);
        add(1, 32'hDEADBEEF, 0, 32'h0,       0, 32'h100,     1, 32'h20,      0, 32'h77777777, 32'h20);
        add(1, 32'h88888888, 0, 32'h0,       0, 32'h104,     1, 32'h100,     1, 32'h88888888, 32'h104);
        add(1, 32'h99999999, 1, 32'h203,     1, 32'h200,     1, 32'h104,     0, 32'h88888888, 32'h104);
        add(0, 32'h0,        1, 32'hFFFFFFFC, 0, 32'hFFFFFFFC, 1, 32'h200,   0, 32'h88888888, 32'h104);
        add(1, 32'h0,        0, 32'h0,       0, 32'hFFFFFFFC, 1, 32'h200,    0, 32'h88888888, 32'h104);
        add(1, 32'hCAFEF00D, 0, 32'h0,       0, 32'h0,       1, 32'hFFFFFFFC, 1, 32'hCAFEF00D, 32'h0);
        add(0, 32'h0,        1, 32'h40,      0, 32'h40,      1, 32'h0,       0, 32'hCAFEF00D, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req",   32'(ifc.ImemReq),    32'h0);
        chk("rst_valid", 32'(ifc.IFID_Valid), 32'h0);
        chk("rst_instr", ifc.IFID_Instr,      32'h0);
        chk("rst_pc4",   ifc.IFID_PCPlus4,    32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].ack, vq[i].data, vq[i].br, vq[i].tgt, vq[i].stall);
            #1;
            chk($sformatf("v%0d_pcnext", i), ifc.PCNext,       vq[i].e_pcnext);
            chk($sformatf("v%0d_req", i),    32'(ifc.ImemReq), 32'(vq[i].e_req));
            chk($sformatf("v%0d_addr", i),   ifc.ImemAddr,     vq[i].e_addr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i),  32'(ifc.IFID_Valid), 32'(vq[i].e_v));
            chk($sformatf("v%0d_instr", i),  ifc.IFID_Instr,      vq[i].e_instr);
            chk($sformatf("v%0d_pc4", i),    ifc.IFID_PCPlus4,    vq[i].e_pc4);
            $display("vec %0d: pc=%h pcnext=%h req=%b valid=%b instr=%h pc4=%h", i,
                     ifc.PCResult, ifc.PCNext, ifc.ImemReq, ifc.IFID_Valid,
                     ifc.IFID_Instr, ifc.IFID_PCPlus4);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of DISCARD (stale request to 0 outstanding).
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("disc_req",  32'(ifc.ImemReq), 32'h1);
        chk("disc_addr", ifc.ImemAddr,     32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_req",    32'(ifc.ImemReq),    32'h0);
        chk("arst_addr",   ifc.ImemAddr,        32'h0);
        chk("arst_valid",  32'(ifc.IFID_Valid), 32'h0);
        chk("arst_instr",  ifc.IFID_Instr,      32'h0);
        chk("arst_pc4",    ifc.IFID_PCPlus4,    32'h0);
        chk("arst_pcnext", ifc.PCNext,          32'h0);
        $display("async reset: req=%b valid=%b instr=%h", ifc.ImemReq, ifc.IFID_Valid, ifc.IFID_Instr);

        // A stray ack during the post-reset IDLE bubble must be ignored.
        drive(1'b1, 32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req", 32'(ifc.ImemReq), 32'h0);
        @(posedge clk);
        #1;
        chk("idle_valid", 32'(ifc.IFID_Valid), 32'h0);
        chk("idle_instr", ifc.IFID_Instr,      32'h0);
        $display("idle ack: valid=%b instr=%h", ifc.IFID_Valid, ifc.IFID_Instr);

        @(negedge clk);
        drive(1'b1, 32'h12345678, 1'b0, 32'h0, 1'b0);
        #1;
        chk("post_req",    32'(ifc.ImemReq), 32'h1);
        chk("post_addr",   ifc.ImemAddr,     32'h0);
        chk("post_pcnext", ifc.PCNext,       32'h4);
        @(posedge clk);
        #1;
        chk("post_valid", 32'(ifc.IFID_Valid), 32'h1);
        chk("post_instr", ifc.IFID_Instr,      32'h12345678);
        chk("post_pc4",   ifc.IFID_PCPlus4,    32'h4);
        $display("first fetch after reset: valid=%b instr=%h pc4=%h",
                 ifc.IFID_Valid, ifc.IFID_Instr, ifc.IFID_PCPlus4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
